// File: rtl/arcade_input_map.sv
// Arcade control mapper: merges PS/2 key table hits with two joysticks, optional
// rotate remap and coin pulse. Define ARCADE_INPUT_AUTOFIRE_EN to build autofire on button 4.
module arcade_input_map #(
    parameter int unsigned NUM_BTN  = 8,
    parameter int unsigned COIN_LEN = 16,
    parameter int unsigned AF_DIV   = 4
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [10:0]        ps2_key,
    input  logic [NUM_BTN-1:0] joy_a,
    input  logic [NUM_BTN-1:0] joy_b,
    input  logic               rotate,
    input  logic               af_enable,
    input  logic               kcfg_wr,
    input  logic [3:0]         kcfg_idx,
    input  logic [9:0]         kcfg_data,
    output logic [NUM_BTN-1:0] btn_out,
    output logic               coin
);

    localparam logic [15:0] COIN_LAST = 16'(COIN_LEN - 1);

    // Table entry layout: {ext_any, code[8:0]}.
    function automatic logic [9:0] tbl_default(input int unsigned idx);
        case (idx)
            0:       return 10'h275;
            1:       return 10'h26B;
            2:       return 10'h272;
            3:       return 10'h274;
            4:       return 10'h029;
            5:       return 10'h214;
            6:       return 10'h005;
            7:       return 10'h006;
            default: return 10'h000;
        endcase
    endfunction

    logic [9:0]         tbl_q [NUM_BTN];
    logic [NUM_BTN-1:0] key_state_q, key_state_d;
    logic [NUM_BTN-1:0] raw, btn_d;
    logic               toggle_q, key_event;
    logic               start, start_q;
    logic               coin_d;
    logic [15:0]        coin_cnt_q, coin_cnt_d;

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam logic [15:0] AF_LAST = 16'(AF_DIV - 1);
    logic        af_active;
    logic        af_phase_q, af_phase_d;
    logic [15:0] af_cnt_q, af_cnt_d;
`else
    logic unused_af;
    assign unused_af = af_enable | (AF_DIV == 0);
`endif

    assign key_event = ps2_key[10] != toggle_q;

    always_comb begin
        logic [9:0] ent;
        key_state_d = key_state_q;
        ent         = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            ent = tbl_q[i];
            if (key_event && ent[7:0] != 8'd0 && ent[7:0] == ps2_key[7:0] &&
                (ent[9] || ent[8] == ps2_key[8])) begin
                key_state_d[i] = ps2_key[9];
            end
            // A config write clears the entry and overrides a same-cycle key event.
            if (kcfg_wr && kcfg_idx == 4'(i)) begin
                key_state_d[i] = 1'b0;
            end
        end
    end

    assign raw = key_state_q | joy_a | joy_b;

    always_comb begin
        btn_d = raw;
        if (rotate) begin
            btn_d[1] = raw[2];
            btn_d[0] = raw[3];
        end
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        af_active  = af_enable && raw[4];
        af_phase_d = 1'b1;
        af_cnt_d   = '0;
        if (af_active) begin
            btn_d[4] = af_phase_q;
            if (af_cnt_q == AF_LAST) begin
                af_phase_d = ~af_phase_q;
            end else begin
                af_phase_d = af_phase_q;
                af_cnt_d   = af_cnt_q + 16'd1;
            end
        end
`endif
    end

    assign start = btn_out[6] | btn_out[7];

    always_comb begin
        coin_d     = coin;
        coin_cnt_d = coin_cnt_q;
        if (coin) begin
            if (coin_cnt_q == 16'd0) begin
                coin_d = 1'b0;
            end else begin
                coin_cnt_d = coin_cnt_q - 16'd1;
            end
        end else if (start && !start_q) begin
            coin_d     = 1'b1;
            coin_cnt_d = COIN_LAST;
        end
    end

    always_ff @(posedge clk_sys) begin
        // Toggle tracks ps2_key even in reset so release does not see a stale event.
        toggle_q <= ps2_key[10];
        if (!reset_n) begin
            key_state_q <= '0;
            btn_out     <= '0;
            coin        <= 1'b0;
            coin_cnt_q  <= '0;
            start_q     <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) begin
                tbl_q[i] <= tbl_default(i);
            end
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            af_phase_q <= 1'b1;
            af_cnt_q   <= '0;
`endif
        end else begin
            key_state_q <= key_state_d;
            btn_out     <= btn_d;
            coin        <= coin_d;
            coin_cnt_q  <= coin_cnt_d;
            start_q     <= start;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (kcfg_wr && kcfg_idx == 4'(i)) begin
                    tbl_q[i] <= kcfg_data;
                end
            end
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            af_phase_q <= af_phase_d;
            af_cnt_q   <= af_cnt_d;
`endif
        end
    end

endmodule
